water_pump_ctrl: RTL and testbench



---
 rtl/water_pump_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_water_pump_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/water_pump_ctrl.sv
// water_pump_ctrl: turns the debounced 3-bit water-level code into fill pump,
// drain valve and alarm commands for one tank.
//
// Optional build macro ALARM_BLINK_EN: when defined, the alarm blinks while in
// FAULT with a half-period of BLINK_HALF cycles. When undefined the alarm is
// steady in FAULT, and no blink counter is built.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | pump and drain off, waiting for a LOW or HIGH level
// FILL  | pump on, tank filling toward NORMAL
// HOLD  | level reached NORMAL after a full minimum run, actuators off
// DRAIN | drain valve on, tank draining toward NORMAL
// FAULT | alarm on, latched until clr_fault with a valid level
module water_pump_ctrl #(
    parameter int DEB_CYCLES   = 4,
    parameter int MIN_ON       = 8,
    parameter int FILL_TIMEOUT = 64,
    parameter int BLINK_HALF   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] warn_led,
    input  logic       stop,
    input  logic       clr_fault,
    output logic       pump_on,
    output logic       drain_on,
    output logic       alarm,
    output logic [2:0] state
);

    localparam int RUN_MAX = (MIN_ON > FILL_TIMEOUT) ? MIN_ON : FILL_TIMEOUT;
    localparam int RUN_W   = $clog2(RUN_MAX) + 1;
    localparam int DEB_W   = $clog2(DEB_CYCLES) + 1;

    localparam logic [RUN_W-1:0] RUN_SAT     = RUN_W'(RUN_MAX);
    localparam logic [RUN_W-1:0] RUN_MIN_ON  = RUN_W'(MIN_ON);
    localparam logic [RUN_W-1:0] RUN_TIMEOUT = RUN_W'(FILL_TIMEOUT);
    localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEB_CYCLES - 1);

    localparam logic [2:0] LVL_OFF    = 3'b000;
    localparam logic [2:0] LVL_LOW    = 3'b001;
    localparam logic [2:0] LVL_NORMAL = 3'b010;
    localparam logic [2:0] LVL_HIGH   = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    // Reject parameter values the debounce and blink counters cannot honour.
    if (DEB_CYCLES < 1) begin : g_deb_chk
        $error("water_pump_ctrl: DEB_CYCLES must be at least 1");
    end
    if (BLINK_HALF < 1) begin : g_blink_chk
        $error("water_pump_ctrl: BLINK_HALF must be at least 1");
    end

    logic [2:0]       samp_q, samp_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [2:0]       lvl_q, lvl_d;

    state_t           state_q, state_d;
    logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
    logic             pump_on_q, pump_on_d;
    logic             drain_on_q, drain_on_d;
    logic             alarm_q, alarm_d;
    logic             lvl_valid;
    logic             run_next;

`ifdef ALARM_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_HALF) + 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
`endif

    // Debounce: lvl only takes samp once samp has been identical DEB_CYCLES times.
    always_comb begin
        samp_d    = warn_led;
        deb_cnt_d = '0;
        if (warn_led == samp_q) begin
            deb_cnt_d = (deb_cnt_q == DEB_LAST) ? deb_cnt_q : deb_cnt_q + 1'b1;
        end
        lvl_d = (deb_cnt_q == DEB_LAST) ? samp_q : lvl_q;
    end

    // Input sample, debounce counter and debounced level registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp_q    <= LVL_OFF;
            deb_cnt_q <= '0;
            lvl_q     <= LVL_OFF;
        end else begin
            samp_q    <= samp_d;
            deb_cnt_q <= deb_cnt_d;
            lvl_q     <= lvl_d;
        end
    end

    // Next state with fault > stop > OFF priority, run timer and output decode.
    always_comb begin
        lvl_valid = (lvl_q == LVL_OFF) || (lvl_q == LVL_LOW) ||
                    (lvl_q == LVL_NORMAL) || (lvl_q == LVL_HIGH);
        state_d = state_q;

        if (state_q == ST_FAULT) begin
            if (clr_fault && lvl_valid) state_d = ST_IDLE;
        end else if (!lvl_valid) begin
            state_d = ST_FAULT;
        end else if (stop || (lvl_q == LVL_OFF)) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_HOLD: begin
                    if (lvl_q == LVL_LOW)       state_d = ST_FILL;
                    else if (lvl_q == LVL_HIGH) state_d = ST_DRAIN;
                end
                ST_FILL: begin
                    // Overflow always wins over the minimum run time.
                    if (lvl_q == LVL_HIGH)
                        state_d = ST_DRAIN;
                    else if ((lvl_q == LVL_NORMAL) && (run_cnt_q >= RUN_MIN_ON))
                        state_d = ST_HOLD;
                    else if ((lvl_q == LVL_LOW) && (run_cnt_q == RUN_TIMEOUT))
                        state_d = ST_FAULT;
                end
                ST_DRAIN: begin
                    if (lvl_q == LVL_LOW)
                        state_d = ST_FILL;
                    else if ((lvl_q == LVL_NORMAL) && (run_cnt_q >= RUN_MIN_ON))
                        state_d = ST_HOLD;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // The run timer restarts on every entry into FILL or DRAIN, including a direct swap.
        run_next  = (state_d == ST_FILL) || (state_d == ST_DRAIN);
        run_cnt_d = run_cnt_q;
        if (run_next && (state_d != state_q)) begin
            run_cnt_d = '0;
        end else if ((state_q == ST_FILL) || (state_q == ST_DRAIN)) begin
            run_cnt_d = (run_cnt_q == RUN_SAT) ? run_cnt_q : run_cnt_q + 1'b1;
        end

        pump_on_d  = (state_d == ST_FILL);
        drain_on_d = (state_d == ST_DRAIN);

`ifdef ALARM_BLINK_EN
        blink_cnt_d = blink_cnt_q;
        alarm_d     = 1'b0;
        if (state_d == ST_FAULT) begin
            if (state_q != ST_FAULT) begin
                blink_cnt_d = '0;
                alarm_d     = 1'b1;
            end else if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                alarm_d     = ~alarm_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
                alarm_d     = alarm_q;
            end
        end
`else
        alarm_d = (state_d == ST_FAULT);
`endif
    end

    // FSM state, run timer and registered actuator outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            run_cnt_q   <= '0;
            pump_on_q   <= 1'b0;
            drain_on_q  <= 1'b0;
            alarm_q     <= 1'b0;
`ifdef ALARM_BLINK_EN
            blink_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            run_cnt_q   <= run_cnt_d;
            pump_on_q   <= pump_on_d;
            drain_on_q  <= drain_on_d;
            alarm_q     <= alarm_d;
`ifdef ALARM_BLINK_EN
            blink_cnt_q <= blink_cnt_d;
`endif
        end
    end

    assign pump_on  = pump_on_q;
    assign drain_on = drain_on_q;
    assign alarm    = alarm_q;
    assign state    = state_q;

endmodule

// File: tb/tb_water_pump_ctrl.sv
// Bench for water_pump_ctrl: directed table of multi-cycle steps, an async
// reset in the middle of a drain, then random level codes, stop and clear
// pulses against a reference model built from the level/transition rules.
module tb_water_pump_ctrl;

    localparam int DEB     = 4;
    localparam int MIN_ON  = 8;
    localparam int FT      = 64;
    localparam int RUN_MAX = (MIN_ON > FT) ? MIN_ON : FT;

    logic       clk;
    logic       rst;
    logic [2:0] warn_led;
    logic       stop;
    logic       clr_fault;
    logic       pump_on;
    logic       drain_on;
    logic       alarm;
    logic [2:0] state;

    int checks;
    int failures;

    water_pump_ctrl #(
        .DEB_CYCLES  (DEB),
        .MIN_ON      (MIN_ON),
        .FILL_TIMEOUT(FT),
        .BLINK_HALF  (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .warn_led (warn_led),
        .stop     (stop),
        .clr_fault(clr_fault),
        .pump_on  (pump_on),
        .drain_on (drain_on),
        .alarm    (alarm),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: level history, state number and cycles spent in the current run.
    int         m_state;
    logic [2:0] m_lvl;
    int         m_run;
    logic [2:0] hist[$];

    function automatic bit code_valid(logic [2:0] c);
        return (c == 3'b000) || (c == 3'b001) || (c == 3'b010) || (c == 3'b100);
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_lvl   = 3'b000;
        m_run   = 0;
        hist.delete();
        hist.push_back(3'b000);
    endtask

    // One clock edge: the FSM reacts to the level known before the edge, and the
    // level becomes the newest sample once the last DEB samples all agree.
    task automatic model_edge();
        int         ns;
        logic [2:0] nl;
        bit         same;
        int         n;
        nl = m_lvl;
        n  = hist.size();
        if (n >= DEB) begin
            same = 1'b1;
            for (int i = n - DEB; i < n; i++)
                if (hist[i] != hist[n-1]) same = 1'b0;
            if (same) nl = hist[n-1];
        end
        hist.push_back(warn_led);
        if (hist.size() > DEB) void'(hist.pop_front());

        ns = m_state;
        if (m_state == 4) begin
            if (clr_fault && code_valid(m_lvl)) ns = 0;
        end else if (!code_valid(m_lvl)) ns = 4;
        else if (stop || m_lvl == 3'b000) ns = 0;
        else if (m_state == 0 || m_state == 2) begin
            if (m_lvl == 3'b001) ns = 1;
            else if (m_lvl == 3'b100) ns = 3;
        end else if (m_state == 1) begin
            if (m_lvl == 3'b100) ns = 3;
            else if (m_lvl == 3'b010 && m_run >= MIN_ON) ns = 2;
            else if (m_lvl == 3'b001 && m_run == FT) ns = 4;
        end else if (m_state == 3) begin
            if (m_lvl == 3'b001) ns = 1;
            else if (m_lvl == 3'b010 && m_run >= MIN_ON) ns = 2;
        end

        if ((ns == 1 || ns == 3) && ns != m_state) m_run = 0;
        else if (m_state == 1 || m_state == 3) m_run = (m_run + 1 > RUN_MAX) ? RUN_MAX : m_run + 1;
        m_state = ns;
        m_lvl   = nl;
    endtask

    task automatic check_vec(string name, logic [5:0] act, logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t: got state=%0d pump=%b drain=%b alarm=%b, expected state=%0d pump=%b drain=%b alarm=%b",
                     name, $time, act[5:3], act[2], act[1], act[0], exp[5:3], exp[2], exp[1], exp[0]);
        end
    endtask

    function automatic logic [5:0] dut_vec();
        return {state, pump_on, drain_on, alarm};
    endfunction

    function automatic logic [5:0] model_vec();
        return {3'(m_state), (m_state == 1), (m_state == 3), (m_state == 4)};
    endfunction

    // One clock: model steps on the edge, DUT compared on the following falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_vec("model", dut_vec(), model_vec());
        checks++;
        if (pump_on && drain_on) begin
            failures++;
            $display("FAIL exclusive t=%0t: got pump_on=1 drain_on=1, expected at most one set", $time);
        end
    endtask

    // Raise rst between clock edges; outputs must clear without waiting for an edge.
    task automatic async_reset(string name);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_vec(name, dut_vec(), 6'b000_000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [2:0] warn;
        logic       stp;
        logic       clr;
        int         n;
        logic [2:0] st;
        logic       pmp;
        logic       drn;
        logic       alm;
    } step_t;

    step_t tbl[$];

    function automatic void add(logic [2:0] w, logic s, logic c, int n,
                                logic [2:0] st, logic p, logic d, logic a);
        step_t e;
        e.warn = w; e.stp = s; e.clr = c; e.n = n;
        e.st = st; e.pmp = p; e.drn = d; e.alm = a;
        tbl.push_back(e);
    endfunction

    initial begin
        logic [2:0] inv_codes[4];
        logic [2:0] code;
        int         r;
        int         dur;

        checks    = 0;
        failures  = 0;
        inv_codes = '{3'b011, 3'b101, 3'b110, 3'b111};

        //   warn    stop  clr   n   state pump drain alarm
        add(3'b001, 1'b0, 1'b0, 5,  3'd0, 1'b0, 1'b0, 1'b0); // lvl LOW not yet seen by FSM
        add(3'b001, 1'b0, 1'b0, 1,  3'd1, 1'b1, 1'b0, 1'b0); // 6th edge: FILL
        add(3'b100, 1'b0, 1'b0, 2,  3'd1, 1'b1, 1'b0, 1'b0); // 2-cycle HIGH glitch
        add(3'b001, 1'b0, 1'b0, 6,  3'd1, 1'b1, 1'b0, 1'b0); // glitch filtered
        add(3'b010, 1'b0, 1'b0, 5,  3'd1, 1'b1, 1'b0, 1'b0);
        add(3'b010, 1'b0, 1'b0, 1,  3'd2, 1'b0, 1'b0, 1'b0); // NORMAL after long run: HOLD
        add(3'b001, 1'b0, 1'b0, 4,  3'd2, 1'b0, 1'b0, 1'b0);
        add(3'b010, 1'b0, 1'b0, 2,  3'd1, 1'b1, 1'b0, 1'b0); // FILL, NORMAL 3 cycles in
        add(3'b010, 1'b0, 1'b0, 8,  3'd1, 1'b1, 1'b0, 1'b0); // held by MIN_ON
        add(3'b010, 1'b0, 1'b0, 1,  3'd2, 1'b0, 1'b0, 1'b0); // run_cnt reached 8
        add(3'b100, 1'b0, 1'b0, 5,  3'd2, 1'b0, 1'b0, 1'b0);
        add(3'b100, 1'b0, 1'b0, 1,  3'd3, 1'b0, 1'b1, 1'b0); // DRAIN
        add(3'b001, 1'b0, 1'b0, 5,  3'd3, 1'b0, 1'b1, 1'b0);
        add(3'b001, 1'b0, 1'b0, 1,  3'd1, 1'b1, 1'b0, 1'b0); // DRAIN->FILL at once
        add(3'b001, 1'b0, 1'b0, 2,  3'd1, 1'b1, 1'b0, 1'b0); // run_cnt=2
        add(3'b100, 1'b0, 1'b0, 5,  3'd1, 1'b1, 1'b0, 1'b0);
        add(3'b100, 1'b0, 1'b0, 1,  3'd3, 1'b0, 1'b1, 1'b0); // overflow ignores MIN_ON
        add(3'b001, 1'b0, 1'b0, 6,  3'd1, 1'b1, 1'b0, 1'b0); // FILL, run from 0
        add(3'b001, 1'b0, 1'b0, 64, 3'd1, 1'b1, 1'b0, 1'b0); // run_cnt=64, still FILL
        add(3'b001, 1'b0, 1'b0, 1,  3'd4, 1'b0, 1'b0, 1'b1); // timeout FAULT
        add(3'b001, 1'b0, 1'b1, 1,  3'd0, 1'b0, 1'b0, 1'b0); // clear with LOW
        add(3'b001, 1'b0, 1'b0, 1,  3'd1, 1'b1, 1'b0, 1'b0); // FILL again
        add(3'b011, 1'b1, 1'b0, 1,  3'd0, 1'b0, 1'b0, 1'b0); // stop
        add(3'b011, 1'b1, 1'b0, 4,  3'd0, 1'b0, 1'b0, 1'b0);
        add(3'b011, 1'b1, 1'b0, 1,  3'd4, 1'b0, 1'b0, 1'b1); // INVALID beats stop
        add(3'b011, 1'b0, 1'b1, 1,  3'd4, 1'b0, 1'b0, 1'b1); // clear ignored while INVALID
        add(3'b001, 1'b1, 1'b0, 5,  3'd4, 1'b0, 1'b0, 1'b1);
        add(3'b001, 1'b1, 1'b1, 1,  3'd0, 1'b0, 1'b0, 1'b0); // cleared
        add(3'b001, 1'b1, 1'b0, 3,  3'd0, 1'b0, 1'b0, 1'b0); // stop holds IDLE
        add(3'b001, 1'b0, 1'b0, 1,  3'd1, 1'b1, 1'b0, 1'b0); // release: FILL next edge
        add(3'b000, 1'b0, 1'b0, 5,  3'd1, 1'b1, 1'b0, 1'b0);
        add(3'b000, 1'b0, 1'b0, 1,  3'd0, 1'b0, 1'b0, 1'b0); // OFF -> IDLE
        add(3'b100, 1'b0, 1'b0, 6,  3'd3, 1'b0, 1'b1, 1'b0); // DRAIN for reset test

        rst       = 1'b1;
        warn_led  = 3'b000;
        stop      = 1'b0;
        clr_fault = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_vec("reset", dut_vec(), 6'b000_000);
        rst = 1'b0;

        for (int s = 0; s < tbl.size(); s++) begin
            warn_led  = tbl[s].warn;
            stop      = tbl[s].stp;
            clr_fault = tbl[s].clr;
            for (int k = 0; k < tbl[s].n; k++) begin
                tick();
                clr_fault = 1'b0;
            end
            check_vec($sformatf("step%0d", s), dut_vec(),
                      {tbl[s].st, tbl[s].pmp, tbl[s].drn, tbl[s].alm});
        end

        async_reset("async_rst_drain");
        warn_led = 3'b000;
        tick();
        check_vec("after_reset", dut_vec(), 6'b000_000);

        for (int seg = 0; seg < 400; seg++) begin
            r = $urandom_range(0, 19);
            if (r < 2)       code = 3'b000;
            else if (r < 8)  code = 3'b001;
            else if (r < 13) code = 3'b010;
            else if (r < 18) code = 3'b100;
            else             code = inv_codes[$urandom_range(0, 3)];
            dur      = ($urandom_range(0, 9) == 0) ? $urandom_range(60, 90) : $urandom_range(1, 14);
            warn_led = code;
            stop     = ($urandom_range(0, 9) == 0);
            for (int k = 0; k < dur; k++) begin
                clr_fault = ($urandom_range(0, 7) == 0);
                tick();
            end
            clr_fault = 1'b0;
            if (seg == 200) async_reset("async_rst_random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
